data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
Two-port arbiter that shares the single-port data memory between the core datapath (port 0) and a debug/loader master (port 1).
- Port 0 has fixed priority.
- A starvation counter guarantees port 1 progress.
- Port 1 may lock the memory for multi-word bursts.
- The block sits between the masters and the data memory; the memory has one-cycle registered read latency.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data word width; must be a multiple of 8.
STARVE_LIMIT, 4, consecutive cycles port 1 may be denied before it is forced through; legal range 1..255.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
m0_req  in  1  port 0 access request, held until granted
m0_we  in  1  port 0 write enable
m0_addr  in  ADDR_WIDTH  port 0 address
m0_wdata  in  DATA_WIDTH  port 0 write data
m0_be  in  DATA_WIDTH/8  port 0 byte enables
m0_gnt  out  1  port 0 access accepted this cycle
m0_rvalid  out  1  port 0 read data valid
m0_rdata  out  DATA_WIDTH  port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_be  in  (same widths)  port 1 request
m1_lock  in  1  port 1 requests to retain ownership after its current grant
m1_gnt, m1_rvalid, m1_rdata  out  (same widths)  port 1 responses
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_be  out  DATA_WIDTH/8  memory byte enables
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read strobe
busy  out  1  high while in LOCK1 or while a read response is pending

Behaviour:
- Reset (rst=0 at posedge): state=ARB, starve_cnt=0, pending-read flag and owner cleared. All gnt, rvalid, mem_en and busy outputs are 0 on the cycle after reset and remain 0 while rst=0; rdata outputs are don't-care.
- Grant is combinational from the current state, starve_cnt and the requests. At most one gnt per cycle. mem_* is driven from the granted port in the same cycle, and mem_en equals m0_gnt|m1_gnt. With no grant, mem_we=0.
- FSM state ARB:
  - If only one port requests, that port is granted.
  - If both request, port 0 wins unless starve_cnt==STARVE_LIMIT, in which case port 1 wins.
  - On a port 1 grant with m1_lock=1, next state is LOCK1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) in each cycle m1_req=1 and m1_gnt=0.
  - Clears to 0 on m1_gnt or when m1_req=0.
- FSM state LOCK1:
  - Port 0 is never granted; m1_req is granted every cycle it is high.
  - Returns to ARB on the first posedge where m1_lock=0. m1_req=0 does not exit LOCK1.
  - starve_cnt is held at 0.
- Read return:
  - A granted read (we=0) sets the pending flag and records the owner.
  - On the next cycle, owner's rvalid=1 and rdata=mem_rdata. rvalid is a single-cycle pulse.
  - Writes never produce rvalid.
  - Back-to-back reads from alternating ports are legal; each response is routed by the owner registered with it.
- Masters must hold req/addr/data stable until gnt. Changing these before gnt is undefined.
- Reset mid-read: the pending response is discarded and no rvalid is issued after reset.
- Simultaneous m1_lock deassert and new m1 request in LOCK1: the request is granted this cycle; ARB applies from the next cycle.

Decomposition:
- Package data_mem_arb_pkg:
  - arb_state_e {ARB, LOCK1}
  - owner_e {OWNER_M0, OWNER_M1}
  - mem_req_t struct {we, addr, wdata, be}
- Sub-module arb_starve_counter: saturating counter with inc/clr/limit-hit outputs, parameterised by STARVE_LIMIT.

Test Plan:
- Reset: hold rst=0 with both reqs high for 3 cycles -> no gnt, mem_en=0, busy=0; after release, m0_gnt=1 in the first cycle.
- Single-port read: m0 read of addr 0x10 where memory holds 0xDEADBEEF -> m0_gnt at cycle t, m0_rvalid=1 and m0_rdata=0xDEADBEEF at t+1, m1_rvalid=0.
- Starvation, STARVE_LIMIT=4: both requesting continuously -> m0 granted at cycles 0-3, m1 granted at cycle 4, starve_cnt back to 0, m0 granted at cycle 5.
- Lock burst: m1 writes 0x1,0x2,0x3 to 0x100/0x104/0x108 with m1_lock=1 on the first two, m0_req held -> m1_gnt 3 consecutive cycles, m0_gnt=0, memory contents match, m0 granted the cycle after m1_lock falls.
- Interleaved reads: m0 reads 0x20, then m1 (forced by starvation) reads 0x24 on consecutive cycles -> m0_rvalid with mem[0x20], then m1_rvalid with mem[0x24], no cross-routing.
- Reset during pending read: rst=0 in the cycle after an m0 read grant -> m0_rvalid stays 0 and busy=0 after reset.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data memory arbiter: FSM state, read-response owner
// and the request bundle steered onto the memory port.
package data_mem_arb_pkg;

  localparam int unsigned ARB_MAX_ADDR_WIDTH = 32;
  localparam int unsigned ARB_MAX_DATA_WIDTH = 32;
  localparam int unsigned STARVE_CNT_WIDTH   = 8;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  // Sized for the widest supported configuration; narrower ones use the low bits.
  typedef struct packed {
    logic                              we;
    logic [ARB_MAX_ADDR_WIDTH-1:0]     addr;
    logic [ARB_MAX_DATA_WIDTH-1:0]     wdata;
    logic [ARB_MAX_DATA_WIDTH/8-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles port 1 was denied; limit_hit
// tells the arbiter to force port 1 through.
module arb_starve_counter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_C = STARVE_CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_WIDTH-1:0] ONE_C   = STARVE_CNT_WIDTH'(1);

  logic [STARVE_CNT_WIDTH-1:0] count_r;

  // Clear has priority over increment; the count sticks at the limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {STARVE_CNT_WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {STARVE_CNT_WIDTH{1'b0}};
    end else if (inc && (count_r != LIMIT_C)) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign limit_hit = (count_r == LIMIT_C);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between the core (port 0, priority) and a
// debug/loader master (port 1, starvation-protected, burst lockable).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic                    m1_lock,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  arb_state_e state_r, state_nxt_s;
  owner_e     owner_r;
  logic       pend_r;
  logic       gnt0_s, gnt1_s, mem_en_s;
  logic       limit_hit_s, starve_inc_s, starve_clr_s;
  mem_req_t   sel_s;

  assign starve_inc_s = m1_req & ~gnt1_s;
  assign starve_clr_s = gnt1_s | ~m1_req | (state_r == LOCK1);

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc       (starve_inc_s),
    .clr       (starve_clr_s),
    .limit_hit (limit_hit_s)
  );

  // Grant decision: port 0 first, port 1 when alone, starved, or holding the lock.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_r)
        ARB: begin
          if (m1_req && (!m0_req || limit_hit_s)) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = m0_req;
          end
        end
        LOCK1:   gnt1_s = m1_req;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Lock is taken on a locked port 1 grant and released when m1_lock drops.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB: begin
        if (gnt1_s && m1_lock) state_nxt_s = LOCK1;
        else                   state_nxt_s = ARB;
      end
      LOCK1: begin
        if (!m1_lock) state_nxt_s = ARB;
        else          state_nxt_s = LOCK1;
      end
      default: state_nxt_s = ARB;
    endcase
  end

  // Steer the granted master onto the memory port; idle port is all zero.
  always_comb begin
    sel_s = '0;
    if (gnt1_s) begin
      sel_s.we                    = m1_we;
      sel_s.addr[ADDR_WIDTH-1:0]  = m1_addr;
      sel_s.wdata[DATA_WIDTH-1:0] = m1_wdata;
      sel_s.be[BE_WIDTH-1:0]      = m1_be;
    end else if (gnt0_s) begin
      sel_s.we                    = m0_we;
      sel_s.addr[ADDR_WIDTH-1:0]  = m0_addr;
      sel_s.wdata[DATA_WIDTH-1:0] = m0_wdata;
      sel_s.be[BE_WIDTH-1:0]      = m0_be;
    end else begin
      sel_s = '0;
    end
  end

  assign mem_en_s  = gnt0_s | gnt1_s;
  assign mem_en    = mem_en_s;
  assign mem_we    = sel_s.we;
  assign mem_addr  = sel_s.addr[ADDR_WIDTH-1:0];
  assign mem_wdata = sel_s.wdata[DATA_WIDTH-1:0];
  assign mem_be    = sel_s.be[BE_WIDTH-1:0];
  assign m0_gnt    = gnt0_s;
  assign m1_gnt    = gnt1_s;

  // FSM state and the owner of the read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ARB;
      pend_r  <= 1'b0;
      owner_r <= OWNER_M0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= mem_en_s & ~sel_s.we;
      if (mem_en_s) owner_r <= gnt1_s ? OWNER_M1 : OWNER_M0;
      else          owner_r <= owner_r;
    end
  end

  // Route the memory's registered read data to the master that issued it.
  always_comb begin
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = {DATA_WIDTH{1'b0}};
    m1_rdata  = {DATA_WIDTH{1'b0}};
    if (rst && pend_r) begin
      if (owner_r == OWNER_M1) begin
        m1_rvalid = 1'b1;
        m1_rdata  = mem_rdata;
      end else begin
        m0_rvalid = 1'b1;
        m0_rdata  = mem_rdata;
      end
    end else begin
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
    end
  end

  assign busy = rst & ((state_r == LOCK1) | pend_r);

endmodule
